// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing one register-file write port among N_REQ writeback sources.
// The granted write is registered one cycle; writes to x0 are consumed but never issued.
module regfile_wr_arbiter #(
    parameter int N_REQ = 3,
    parameter int AW    = 5,
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*AW-1:0] req_addr,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]    req_ready,
    output logic                reg_wr,
    output logic [AW-1:0]       waddr,
    output logic [DW-1:0]       wdata,
    output logic [CNT_W-1:0]    wr_count
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] ptr_nxt_p0;
    logic [N_REQ-1:0] gnt_p0;
    logic [AW-1:0]    win_addr_p0;
    logic [DW-1:0]    win_data_p0;
    logic             vld_p0;
    logic             issue_p0;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v)
            return v;
        return v + 1'b1;
    endfunction

    // Stage p0: combinational round-robin scan starting at rr_ptr
    always_comb begin
        logic             found;
        logic [PTR_W-1:0] sel;
        int               idx;
        found       = 1'b0;
        sel         = '0;
        idx         = 0;
        gnt_p0      = '0;
        win_addr_p0 = '0;
        win_data_p0 = '0;
        ptr_nxt_p0  = rr_ptr;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % N_REQ;
            sel = PTR_W'(idx);
            if (en && !found && req_valid[sel]) begin
                found       = 1'b1;
                gnt_p0[sel] = 1'b1;
                win_addr_p0 = req_addr[sel*AW +: AW];
                win_data_p0 = req_data[sel*DW +: DW];
                ptr_nxt_p0  = PTR_W'((idx + 1) % N_REQ);
            end
        end
    end

    assign req_ready = rst ? '0 : gnt_p0;
    assign vld_p0    = |(req_valid & req_ready);
    assign issue_p0  = vld_p0 && (win_addr_p0 != '0);

    // Stage p1: registered write toward the register file
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr   <= '0;
            reg_wr   <= 1'b0;
            waddr    <= '0;
            wdata    <= '0;
            wr_count <= '0;
        end else begin
            reg_wr <= issue_p0;
            if (vld_p0)
                rr_ptr <= ptr_nxt_p0;
            if (issue_p0) begin
                waddr    <= win_addr_p0;
                wdata    <= win_data_p0;
                wr_count <= sat_inc(wr_count);
            end
        end
    end

endmodule
